ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to the keyboard on the shared PS/2 clock/data lines. It is the transmit counterpart of the keyboard receiver and sits beside it on the same two open-drain lines. The CPU-side handshake is start/busy/done, with error pulses for a missing acknowledge or a timeout.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles the host holds ps2c low before the request-to-send (100 us at 50 MHz)
REQ_CYCLES, 50, clk cycles ps2d is held low before ps2c is released
TIMEOUT_CYCLES, 750000, max clk cycles from ps2c release to end of frame (15 ms at 50 MHz); used only with the optional feature
FILTER_LEN, 8, ps2c glitch-filter depth in samples

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to send din; ignored while busy=1
din  in  8  command byte; sampled only on an accepted start
ps2c_in  in  1  PS/2 clock line as read
ps2d_in  in  1  PS/2 data line as read
ps2c_oe  out  1  1 = pull ps2c low; 0 = release
ps2d_oe  out  1  1 = pull ps2d low; 0 = release
busy  out  1  high from an accepted start until done_tick or err_tick
done_tick  out  1  one-cycle pulse: frame sent and device ACK seen
err_tick  out  1  one-cycle pulse: ACK missing or timeout

Behaviour:
- Reset: state=IDLE, ps2c_oe=0, ps2d_oe=0, busy=0, done_tick=0, err_tick=0, filter cleared to all-ones (line idle high).
- Clock filter: ps2c_in goes through a FILTER_LEN-deep shift register.
  - Filtered level updates only when the register is all ones or all zeros.
  - fall_edge pulses one cycle after the filtered level goes 1->0.
- Frame: {odd_parity, din[7:0]} is latched on the accepted start. odd_parity = ~^din.
- FSM:
  - IDLE: start=1 -> latch the frame, busy=1, ps2c_oe=1, counter=0, go to INHIBIT. Starts that arrive while busy are dropped with no effect.
  - INHIBIT: when counter reaches INHIBIT_CYCLES-1 -> ps2d_oe=1 (start bit 0), go to REQ.
  - REQ: after REQ_CYCLES -> ps2c_oe=0 (release), bitcnt=0, go to SEND.
  - SEND: on each fall_edge, drive the next bit with ps2d_oe = ~bit.
    - Edges 1-8 drive din[0]..din[7].
    - Edge 9 drives parity.
    - Edge 10 releases ps2d (stop bit = 1) and moves to ACK.
  - ACK: on the next fall_edge, sample ps2d_in.
    - 0 -> go to WAIT_IDLE.
    - 1 -> err_tick, go to IDLE.
  - WAIT_IDLE: filtered ps2c=1 and ps2d_in=1 -> done_tick, busy=0, go to IDLE.
- All data changes happen on filtered falling edges only, i.e. while the device holds ps2c low.
- done_tick and err_tick are mutually exclusive. busy drops in the same cycle as either pulse.
- The receiver must be held off while busy=1; the top level gates the receiver's status with busy.
- Reset mid-frame: both lines are released in the same cycle and the FSM returns to IDLE with no pulse.
- No reset, no start: outputs are constant and both lines stay released.

Optional Feature:
PS2_TX_TIMEOUT_EN
- Defined: a watchdog counter runs from entry into SEND until exit from WAIT_IDLE. If it reaches TIMEOUT_CYCLES, the block releases both lines, pulses err_tick and returns to IDLE. This covers an unplugged keyboard.
- Undefined: no watchdog. The FSM waits indefinitely for device edges and err_tick fires only on a NACK.

Decomposition:
- Package ps2_pkg holds:
  - tx state enum (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE)
  - PS2_DATA_BITS=8
  - PS2_FRAME_BITS=11
  - odd-parity function
- One sub-module, ps2_clk_filter: ps2c filter plus fall_edge generation, shared with the receiver.

Test Plan:
- din=0xED, start pulse, device model clocks 11 edges and ACKs -> ps2c_oe high for 5000 cycles; host bits 1,0,1,1,0,1,1,1 then parity=1; ps2d released at edge 10; one done_tick; busy low afterwards.
- din=0xF4 -> bits 0,0,1,0,1,1,1,1, parity=0, done_tick.
- Device leaves ps2d high at edge 11 (NACK) -> err_tick=1 once, no done_tick, both oe=0.
- start pulsed again mid-frame with din=0x00 -> ignored; the frame still carries the original byte.
- rst asserted after edge 5 -> next cycle ps2c_oe=0, ps2d_oe=0, busy=0, no pulse.
- With PS2_TX_TIMEOUT_EN, device never clocks -> err_tick exactly TIMEOUT_CYCLES after ps2c release. Without the macro -> busy stays 1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame geometry, host-transmit state encoding and parity helper.
package ps2_pkg;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } tx_state_e;

  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock glitch filter with a one-cycle falling-edge pulse; shared by the host transmitter
// and the keyboard receiver.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2c_in,
  output logic level,
  output logic fall_edge
);

  logic [FILTER_LEN-1:0] sr_q;
  logic [FILTER_LEN-1:0] sr_nxt;
  logic                  level_q;
  logic                  level_d_q;
  logic                  fall_q;

  assign sr_nxt = {sr_q[FILTER_LEN-2:0], ps2c_in};

  // Level only moves once the whole window agrees; anything shorter is treated as a glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q      <= '1;
      level_q   <= 1'b1;
      level_d_q <= 1'b1;
      fall_q    <= 1'b0;
    end else begin
      sr_q <= sr_nxt;
      if (&sr_nxt)
        level_q <= 1'b1;
      else if (~|sr_nxt)
        level_q <= 1'b0;
      level_d_q <= level_q;
      fall_q    <= level_d_q & ~level_q;
    end
  end

  assign level     = level_q;
  assign fall_edge = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, 10 bits out, ACK check).
// Optional watchdog for a silent/unplugged device: define PS2_TX_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | lines released, waiting for start
// INHIBIT   | host holds ps2c low
// REQ       | host holds ps2c and ps2d low (start bit), then releases ps2c
// SEND      | device clocks; data, parity, then stop (ps2d released)
// ACK       | waiting for the device ACK edge
// WAIT_IDLE | ACK seen, waiting for both lines to return high
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [PS2_DATA_BITS-1:0] din,
  input  logic                     ps2c_in,
  input  logic                     ps2d_in,
  output logic                     ps2c_oe,
  output logic                     ps2d_oe,
  output logic                     busy,
  output logic                     done_tick,
  output logic                     err_tick
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [3:0] LAST_DATA_EDGE = 4'(PS2_DATA_BITS);

  tx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [3:0]             bitcnt_q;
  logic [PS2_DATA_BITS:0] frame_q;
  logic                   drive_low_q;
  logic                   done_q, err_q;
  logic                   done_d, err_d;
  logic                   c_level, fall_edge;
  logic                   inhibit_tc, req_tc, timeout;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk       (clk),
    .rst       (rst),
    .ps2c_in   (ps2c_in),
    .level     (c_level),
    .fall_edge (fall_edge)
  );

  assign inhibit_tc = (cnt_q == CNT_W'(INHIBIT_CYCLES - 1));
  assign req_tc     = (cnt_q == CNT_W'(REQ_CYCLES - 1));

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wd_q;
  logic            wd_run;

  assign wd_run = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);

  always_ff @(posedge clk) begin
    if (rst)
      wd_q <= '0;
    else if (state_q == REQ)
      wd_q <= '0;
    else if (wd_run)
      wd_q <= wd_q + 1'b1;
  end

  assign timeout = wd_run && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      frame_q     <= '0;
      drive_low_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            frame_q     <= {odd_parity(din), din};
            cnt_q       <= '0;
            drive_low_q <= 1'b0;
          end
        end
        INHIBIT: begin
          if (inhibit_tc) begin
            cnt_q       <= '0;
            drive_low_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        REQ: begin
          bitcnt_q <= '0;
          if (!req_tc)
            cnt_q <= cnt_q + 1'b1;
        end
        SEND: begin
          // Edges 1..9 put data then parity on the line; edge 10 lets it float high as stop.
          if (fall_edge) begin
            if (bitcnt_q <= LAST_DATA_EDGE)
              drive_low_q <= ~frame_q[bitcnt_q];
            else
              drive_low_q <= 1'b0;
            bitcnt_q <= bitcnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE:      if (start) state_d = INHIBIT;
      INHIBIT:   if (inhibit_tc) state_d = REQ;
      REQ:       if (req_tc) state_d = SEND;
      SEND:      if (fall_edge && (bitcnt_q == LAST_DATA_EDGE + 4'd1)) state_d = ACK;
      ACK: begin
        if (fall_edge) begin
          if (ps2d_in) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (c_level && ps2d_in) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default:   state_d = IDLE;
    endcase
    if (timeout) begin
      state_d = IDLE;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  always_comb begin
    ps2c_oe   = (state_q == INHIBIT) || (state_q == REQ);
    ps2d_oe   = ((state_q == REQ) || (state_q == SEND)) && drive_low_q;
    busy      = (state_q != IDLE);
    done_tick = done_q;
    err_tick  = err_q;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural keyboard clocks frames and ACKs/NACKs them.
module tb_ps2_host_tx;

  localparam int INH  = 5000;
  localparam int REQ  = 50;
  localparam int TO   = 3000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] din;
  logic       dev_c, dev_d;
  logic       ps2c_oe, ps2d_oe, busy, done_tick, err_tick;
  wire        ps2c_line = ~ps2c_oe & dev_c;
  wire        ps2d_line = ~ps2d_oe & dev_d;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .REQ_CYCLES     (REQ),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .ps2c_in   (ps2c_line),
    .ps2d_in   (ps2d_line),
    .ps2c_oe   (ps2c_oe),
    .ps2d_oe   (ps2d_oe),
    .busy      (busy),
    .done_tick (done_tick),
    .err_tick  (err_tick)
  );

  always @(negedge clk) begin
    if (done_tick) done_cnt++;
    if (err_tick)  err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_start(input logic [7:0] d);
    @(negedge clk);
    din   = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Measures how long the host holds ps2c alone, then ps2c and ps2d, before releasing ps2c.
  task automatic host_phase(input string tag);
    int n;
    n = 0;
    while (ps2c_oe && !ps2d_oe && n < INH + 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_inhibit"}, n, INH);
    n = 0;
    while (ps2c_oe && n < REQ + 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_req"}, n, REQ);
  endtask

  task automatic dev_frame(input logic ack, input int restart_at, input int abort_at,
                           output logic [10:0] bits);
    bits    = '0;
    bits[0] = ps2d_line;
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      dev_c = 1'b0;
      repeat (HALF) @(negedge clk);
      bits[k] = ps2d_line;
      if (k == abort_at) begin
        chk("abort_d_driven", ps2d_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_c_oe", ps2c_oe, 0);
        chk("abort_d_oe", ps2d_oe, 0);
        chk("abort_busy", busy, 0);
        dev_c = 1'b1;
        return;
      end
      dev_c = 1'b1;
      if (k == restart_at) begin
        din   = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", busy, 1);
      end
      repeat (HALF) @(negedge clk);
    end
    dev_d = ack ? 1'b0 : 1'b1;
    repeat (4) @(negedge clk);
    dev_c = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_c = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_d = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic ack,
                           input int restart_at, input logic [10:0] exp_bits);
    logic [10:0] bits;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_start(d);
    chk({tag, "_busy_start"}, busy, 1);
    host_phase(tag);
    dev_frame(ack, restart_at, 0, bits);
    chk({tag, "_bits"}, bits, exp_bits);
    chk({tag, "_done"}, done_cnt - d0, ack ? 1 : 0);
    chk({tag, "_err"}, err_cnt - e0, ack ? 0 : 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_lines"}, {ps2c_oe, ps2d_oe}, 0);
  endtask

  initial begin
    int d0, e0, n;
    logic [10:0] bits;
    rst   = 1'b1;
    start = 1'b0;
    din   = 8'h00;
    dev_c = 1'b1;
    dev_d = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_c_oe", ps2c_oe, 0);
    chk("rst_d_oe", ps2d_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ticks", {done_tick, err_tick}, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_quiet", {ps2c_oe, ps2d_oe, busy, done_tick, err_tick}, 0);

    // Frames as {stop, parity, d7..d0, start}.
    run_frame("ed", 8'hED, 1'b1, 0, 11'h7DA);
    run_frame("f4", 8'hF4, 1'b1, 0, 11'h5E8);
    run_frame("restart", 8'hED, 1'b1, 3, 11'h7DA);
    run_frame("nack", 8'h55, 1'b0, 0, 11'h6AA);

    d0 = done_cnt;
    e0 = err_cnt;
    send_start(8'hED);
    host_phase("abort");
    dev_frame(1'b1, 0, 5, bits);
    repeat (30) @(negedge clk);
    chk("abort_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    chk("abort_idle", busy, 0);

    e0 = err_cnt;
    d0 = done_cnt;
    send_start(8'hF4);
    host_phase("to");
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (!err_tick && n < TO + 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", n, TO);
    chk("to_busy", busy, 0);
    chk("to_lines", {ps2c_oe, ps2d_oe}, 0);
    repeat (5) @(negedge clk);
    chk("to_err_once", err_cnt - e0, 1);
`else
    n = 0;
    repeat (TO + 100) @(negedge clk);
    chk("to_busy_held", busy, 1);
    chk("to_no_err", err_cnt - e0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    chk("to_no_done", done_cnt - d0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
